// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that lends one SPI byte engine to N_REQ requesters for whole framed transactions.
// Grant 1 cycle after req, eng_start/ack 1 cycle later; launch stalls while eng_busy, rx_valid 1 cycle after eng_finished.
module spi_bus_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    rx_valid,
  output logic [DW-1:0]       rx_data,
  output logic [N_REQ-1:0]    err,
  output logic                eng_start,
  output logic [DW-1:0]       eng_data,
  input  logic                eng_busy,
  input  logic                eng_finished,
  input  logic [DW-1:0]       eng_data_out
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             last_q, last_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [N_REQ-1:0] gnt_d, ack_d, rx_valid_d, err_d;
  logic [DW-1:0]    rx_data_d, eng_data_d;
  logic             eng_start_d;

  logic [PW-1:0]    pick;
  logic             pick_vld;
  logic [N_REQ-1:0] pick_oh, owner_oh;
  logic [PW-1:0]    ptr_after_owner;

  // (base + off) mod N_REQ, valid for off < N_REQ
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  // Walk offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[rr_idx(ptr_q, i)]) begin
        pick     = rr_idx(ptr_q, i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh           = '0;
    pick_oh[pick]     = 1'b1;
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    ptr_after_owner   = rr_idx(owner_q, 1);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wdog_d      = wdog_q;
    gnt_d       = gnt;
    ack_d       = '0;
    rx_valid_d  = '0;
    err_d       = '0;
    eng_start_d = 1'b0;
    rx_data_d   = rx_data;
    eng_data_d  = eng_data;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          gnt_d   = pick_oh;
          state_d = LAUNCH;
        end
      end

      LAUNCH: begin
        if (!req[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          state_d = IDLE;
        end else if (!eng_busy) begin
          eng_data_d  = req_data[int'(owner_q)*DW +: DW];
          last_d      = req_last[owner_q];
          eng_start_d = 1'b1;
          ack_d       = owner_oh;
          wdog_d      = '0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        wdog_d = wdog_q + WW'(1);
        // A byte completion on the very cycle the watchdog expires still counts as success.
        if (eng_finished) begin
          rx_data_d  = eng_data_out;
          rx_valid_d = owner_oh;
          if (last_q || !req[owner_q]) begin
            gnt_d   = '0;
            ptr_d   = ptr_after_owner;
            state_d = IDLE;
          end else begin
            state_d = LAUNCH;
          end
        end else if (wdog_d == WW'(TIMEOUT)) begin
          err_d   = owner_oh;
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          state_d = IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      last_q    <= 1'b0;
      wdog_q    <= '0;
      gnt       <= '0;
      ack       <= '0;
      rx_valid  <= '0;
      err       <= '0;
      eng_start <= 1'b0;
      rx_data   <= '0;
      eng_data  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      gnt       <= gnt_d;
      ack       <= ack_d;
      rx_valid  <= rx_valid_d;
      err       <= err_d;
      eng_start <= eng_start_d;
      rx_data   <= rx_data_d;
      eng_data  <= eng_data_d;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random multi-requester traffic against a transaction-level model.
module tb_spi_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 24;  // long enough for the 20-cycle engine response in the single-byte case

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt, ack, rx_valid, err;
  logic [DW-1:0] rx_data, eng_data, eng_data_out;
  logic          eng_start, eng_busy, eng_finished;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .gnt(gnt), .ack(ack), .rx_valid(rx_valid), .rx_data(rx_data), .err(err),
    .eng_start(eng_start), .eng_data(eng_data), .eng_busy(eng_busy),
    .eng_finished(eng_finished), .eng_data_out(eng_data_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic int oh_index(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  // Engine model: answers each eng_start after a delay with a 1-cycle finished pulse.
  bit         eng_auto = 0, eng_rand = 0, eng_fixed_en = 0;
  int         eng_delay = 1, eng_rem = 0;
  logic [7:0] eng_fixed = '0, eng_resp = '0;

  task automatic engine_update();
    eng_finished = 1'b0;
    if (!eng_auto) return;
    if (eng_rem > 0) begin
      eng_rem--;
      if (eng_rem == 0) begin
        eng_finished = 1'b1;
        eng_busy     = 1'b0;
        eng_data_out = eng_resp;
      end
    end
    if (eng_start) begin
      eng_rem  = eng_rand ? int'($urandom_range(1, 10)) : eng_delay;
      eng_busy = 1'b1;
      eng_resp = eng_fixed_en ? eng_fixed : 8'($urandom);
    end
  endtask

  // Random requesters: each runs transactions of 1..4 bytes, advancing on ack.
  bit         rand_mode = 0;
  logic [7:0] tx_bytes [N][4];
  int         tx_len [N], tx_idx [N], tx_gap [N];
  bit         tx_act [N];
  int         done_txn = 0;

  task automatic requester_update();
    for (int i = 0; i < N; i++) begin
      if (tx_act[i]) begin
        if (ack[i]) tx_idx[i]++;
        if (rx_valid[i] && tx_idx[i] == tx_len[i]) begin
          tx_act[i] = 0;
          tx_gap[i] = $urandom_range(0, 4);
          done_txn++;
        end
      end else if (tx_gap[i] > 0) begin
        tx_gap[i]--;
      end else if ($urandom_range(0, 1) == 1) begin
        tx_len[i] = $urandom_range(1, 4);
        for (int j = 0; j < 4; j++) tx_bytes[i][j] = 8'($urandom);
        tx_idx[i] = 0;
        tx_act[i] = 1;
      end
      req[i] = tx_act[i];
      if (tx_act[i] && tx_idx[i] < tx_len[i]) begin
        req_data[i*DW +: DW] = tx_bytes[i][tx_idx[i]];
        req_last[i]          = (tx_idx[i] == tx_len[i] - 1);
      end
    end
  endtask

  // Transaction-level expectations: who should own the bus, when bytes launch and return.
  int         m_ptr, m_owner;
  bit         m_last, m_start_due, m_rxv_due;
  logic [N-1:0] m_prev_gnt;
  logic [7:0] m_rx_exp;

  task automatic model_check();
    logic [N-1:0] exp_gnt, exp_rxv;
    logic [31:0]  exp_byte;
    int p;
    bit nxt_start;
    exp_rxv = '0;
    if (m_rxv_due) exp_rxv[m_owner] = 1'b1;
    check_eq("rx_valid", 32'(rx_valid), 32'(exp_rxv));
    if (m_rxv_due) check_eq("rx_data", 32'(rx_data), 32'(m_rx_exp));
    exp_gnt = m_prev_gnt;
    if (m_prev_gnt == '0) begin
      p = rr_pick(req, m_ptr);
      if (p >= 0) exp_gnt[p] = 1'b1;
    end else if (m_rxv_due && m_last) begin
      exp_gnt = '0;
      m_ptr   = (m_owner + 1) % N;
    end
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("eng_start", 32'(eng_start), 32'(m_start_due));
    check_eq("ack", 32'(ack), m_start_due ? 32'(exp_gnt) : 32'h0);
    check_eq("err", 32'(err), 32'h0);
    nxt_start = (m_prev_gnt == '0 && exp_gnt != '0) || (m_rxv_due && !m_last);
    if (m_start_due) begin
      m_owner  = oh_index(exp_gnt);
      exp_byte = 32'hDEAD;
      if (m_owner >= 0 && tx_idx[m_owner] < tx_len[m_owner]) exp_byte = 32'(tx_bytes[m_owner][tx_idx[m_owner]]);
      check_eq("eng_data", 32'(eng_data), exp_byte);
      if (m_owner >= 0) m_last = (tx_idx[m_owner] == tx_len[m_owner] - 1);
    end
    m_start_due = nxt_start;
    m_prev_gnt  = exp_gnt;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rand_mode) model_check();
    engine_update();
    if (rand_mode) begin
      m_rxv_due = eng_finished;
      m_rx_exp  = eng_data_out;
      requester_update();
    end
  endtask

  task automatic set_req(input int i, input bit r, input bit l, input logic [7:0] d);
    req[i]               = r;
    req_last[i]          = l;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; req_last = '0; req_data = '0;
    eng_busy = 1'b0; eng_finished = 1'b0; eng_data_out = '0;
    eng_auto = 0; eng_rem = 0;
    step();
    step();
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_eng_start", 32'(eng_start), 32'h0);
    check_eq("rst_rx_data", 32'(rx_data), 32'h0);
    check_eq("rst_eng_data", 32'(eng_data), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    int t, n_st, n_rx, nb, ng, bad;
    bit seen, sawrx;
    logic [7:0] got [3];
    int order [5];

    // Single-byte transaction with a slow engine.
    do_reset();
    eng_auto = 1; eng_rand = 0; eng_delay = 20; eng_fixed_en = 1; eng_fixed = 8'h3C;
    set_req(0, 1, 1, 8'hA5);
    step();
    check_eq("t1_gnt_c1", 32'(gnt), 32'h1);
    check_eq("t1_nostart_c1", 32'(eng_start), 32'h0);
    step();
    check_eq("t1_start_c2", 32'(eng_start), 32'h1);
    check_eq("t1_ack_c2", 32'(ack), 32'h1);
    check_eq("t1_eng_data", 32'(eng_data), 32'hA5);
    t = 2;
    while (rx_valid == '0 && t < 60) begin step(); t++; end
    check_eq("t1_rx_cycle", t, 23);
    check_eq("t1_rx_valid", 32'(rx_valid), 32'h1);
    check_eq("t1_rx_data", 32'(rx_data), 32'h3C);
    check_eq("t1_gnt_released", 32'(gnt), 32'h0);
    set_req(0, 0, 0, 8'h00);
    step();
    check_eq("t1_rxv_pulse", 32'(rx_valid), 32'h0);
    check_eq("t1_rx_data_held", 32'(rx_data), 32'h3C);

    // Three-byte burst from requester 2.
    do_reset();
    eng_auto = 1; eng_delay = 5; eng_fixed_en = 0;
    set_req(2, 1, 0, 8'h01);
    n_st = 0; n_rx = 0; nb = 0; bad = 0; seen = 0;
    for (int k = 0; k < 200 && n_rx < 3; k++) begin
      step();
      if (eng_start) begin
        if (n_st < 3) got[n_st] = eng_data;
        n_st++;
      end
      if (rx_valid != '0) begin
        check_eq("t2_rx_valid", 32'(rx_valid), 32'h4);
        check_eq("t2_rx_data", 32'(rx_data), 32'(eng_data_out));
        n_rx++;
      end
      if (gnt == 4'b0100) seen = 1;
      if ((gnt != '0 && gnt != 4'b0100) || (seen && n_rx < 3 && gnt != 4'b0100)) bad++;
      if (ack[2]) begin
        nb++;
        if (nb < 3) set_req(2, 1, nb == 2, 8'(nb + 1));
      end
    end
    check_eq("t2_starts", n_st, 3);
    check_eq("t2_byte0", 32'(got[0]), 32'h01);
    check_eq("t2_byte1", 32'(got[1]), 32'h02);
    check_eq("t2_byte2", 32'(got[2]), 32'h03);
    check_eq("t2_rx_count", n_rx, 3);
    check_eq("t2_gnt_stable", bad, 0);
    check_eq("t2_gnt_released", 32'(gnt), 32'h0);

    // Round robin with all four requesting single bytes.
    do_reset();
    eng_auto = 1; eng_delay = 3;
    for (int i = 0; i < N; i++) set_req(i, 1, 1, 8'($urandom));
    ng = 0;
    for (int k = 0; k < 5; k++) order[k] = -1;
    begin
      logic [N-1:0] prev_g;
      prev_g = '0;
      for (int k = 0; k < 300 && ng < 5; k++) begin
        step();
        if (gnt != '0 && gnt != prev_g) begin
          order[ng] = oh_index(gnt);
          ng++;
        end
        prev_g = gnt;
      end
    end
    for (int k = 0; k < 5; k++) check_eq($sformatf("t3_order%0d", k), order[k], k % N);

    // Withdrawal while the engine is still busy.
    do_reset();
    eng_auto = 0; eng_busy = 1'b1;
    set_req(1, 1, 1, 8'h11);
    set_req(2, 1, 1, 8'h22);
    step();
    check_eq("t4_gnt1", 32'(gnt), 32'h2);
    step();
    check_eq("t4_hold_nostart", 32'(eng_start), 32'h0);
    check_eq("t4_hold_gnt", 32'(gnt), 32'h2);
    set_req(1, 0, 0, 8'h00);
    step();
    check_eq("t4_gnt_cleared", 32'(gnt), 32'h0);
    check_eq("t4_no_ack", 32'(ack), 32'h0);
    step();
    check_eq("t4_gnt2", 32'(gnt), 32'h4);
    eng_busy = 1'b0;
    step();
    check_eq("t4_start2", 32'(eng_start), 32'h1);
    check_eq("t4_data2", 32'(eng_data), 32'h22);

    // Watchdog expiry, then a stray finished pulse.
    do_reset();
    eng_auto = 0;
    set_req(3, 1, 1, 8'h77);
    step();
    step();
    check_eq("t5_start", 32'(eng_start), 32'h1);
    t = 2; sawrx = 0;
    while (err == '0 && t < 100) begin
      step(); t++;
      if (rx_valid != '0) sawrx = 1;
    end
    check_eq("t5_err_cycle", t, 2 + TO);
    check_eq("t5_err_owner", 32'(err), 32'h8);
    check_eq("t5_gnt_released", 32'(gnt), 32'h0);
    set_req(3, 0, 0, 8'h00);
    step();
    check_eq("t5_err_pulse", 32'(err), 32'h0);
    eng_finished = 1'b1; eng_data_out = 8'h5C;
    step();
    if (rx_valid != '0) sawrx = 1;
    step();
    if (rx_valid != '0) sawrx = 1;
    check_eq("t5_no_stray_rx", 32'(sawrx), 32'h0);

    // Reset in the middle of a byte; pointer must restart at 0.
    do_reset();
    eng_auto = 1; eng_delay = 4; eng_fixed_en = 1; eng_fixed = 8'h5A;
    set_req(1, 1, 1, 8'h99);
    for (int k = 0; k < 50 && rx_valid == '0; k++) step();
    check_eq("t6_first_rx", 32'(rx_valid), 32'h2);
    set_req(1, 0, 0, 8'h99);
    step();
    step();
    eng_auto = 0; eng_fixed_en = 0;
    set_req(1, 1, 1, 8'h99);
    for (int k = 0; k < 20 && !eng_start; k++) step();
    check_eq("t6_second_start", 32'(eng_start), 32'h1);
    step(); step(); step();
    rst = 1'b1;
    step();
    check_eq("t6_rst_gnt", 32'(gnt), 32'h0);
    check_eq("t6_rst_rx_data", 32'(rx_data), 32'h0);
    check_eq("t6_rst_eng_data", 32'(eng_data), 32'h0);
    check_eq("t6_rst_start", 32'(eng_start), 32'h0);
    rst = 1'b0;
    set_req(3, 1, 1, 8'h33);
    eng_finished = 1'b1; eng_data_out = 8'hEE;
    step();
    check_eq("t6_late_finish_ignored", 32'(rx_valid), 32'h0);
    check_eq("t6_ptr0_grant", 32'(gnt), 32'h2);

    // Random traffic from all requesters against the transaction model.
    do_reset();
    for (int i = 0; i < N; i++) begin
      tx_act[i] = 0; tx_gap[i] = $urandom_range(0, 3); tx_len[i] = 1; tx_idx[i] = 0;
    end
    m_ptr = 0; m_owner = 0; m_last = 0; m_start_due = 0; m_rxv_due = 0; m_prev_gnt = '0; m_rx_exp = '0;
    eng_auto = 1; eng_rand = 1; eng_fixed_en = 0;
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    check_eq("rand_progress", 32'(done_txn >= 30), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
